// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Logic, shift, add and subtract finish in
// one cycle; shift-add multiply and restoring divide iterate for WIDTH cycles.
// Each result is held with its high/remainder word and error flag until accepted.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9
   } op_t;

   state_t           state;
   logic             is_mul;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic [SHW-1:0]   cnt;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_out;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_err;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] it_acc;
   logic [WIDTH-1:0] it_quo;

   assign in_ready = (state == IDLE) && !reset;

   // Single-cycle result for everything except MUL and DIV with nonzero divisor
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      sc_out = '0;
      sc_hi  = '0;
      sc_err = 1'b0;
      case (op)
         OP_ADD: begin
            sc_out = sum[WIDTH-1:0];
            sc_err = sum[WIDTH];
         end
         OP_SUB: begin
            sc_out = a - b;
            sc_err = (a < b);
         end
         OP_MUL: ;
         OP_DIV: begin
            sc_out = '1;
            sc_hi  = a;
            sc_err = 1'b1;
         end
         OP_AND: sc_out = a & b;
         OP_OR:  sc_out = a | b;
         OP_XOR: sc_out = a ^ b;
         OP_NOT: sc_out = ~a;
         OP_SHL: sc_out = a << b[SHW-1:0];
         OP_SHR: sc_out = a >> b[SHW-1:0];
         default: sc_err = 1'b1;
      endcase
   end

   // One iteration step: acc/quo hold {product hi, lo} for MUL, {remainder, quotient} for DIV
   always_comb begin
      mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, b_q} : '0);
      div_shift = {acc, quo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_diff  = div_shift[WIDTH-1:0] - b_q;
      if (is_mul) begin
         it_acc = mul_sum[WIDTH:1];
         it_quo = {mul_sum[0], quo[WIDTH-1:1]};
      end else begin
         it_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
         it_quo = {quo[WIDTH-2:0], div_ge};
      end
   end

   // Control FSM with registered result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         is_mul    <= 1'b0;
         b_q       <= '0;
         acc       <= '0;
         quo       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out       <= '0;
         out_hi    <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  b_q <= b;
                  cnt <= '0;
                  acc <= '0;
                  quo <= a;
                  if (op == OP_MUL) begin
                     is_mul <= 1'b1;
                     state  <= BUSY;
                  end else if (op == OP_DIV && b != '0) begin
                     is_mul <= 1'b0;
                     state  <= BUSY;
                  end else begin
                     out       <= sc_out;
                     out_hi    <= sc_hi;
                     err       <= sc_err;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               acc <= it_acc;
               quo <= it_quo;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out       <= it_quo;
                  out_hi    <= it_acc;
                  err       <= is_mul ? (|it_acc) : 1'b0;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
